// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C SCL timing generator.
package i2c_pkg;

    // Generator control states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        STRETCH = 2'd2
    } scl_state_t;

    // SCL period quarters: two low quarters followed by two high quarters.
    typedef enum logic [1:0] {
        PH_LOW0  = 2'd0,
        PH_LOW1  = 2'd1,
        PH_HIGH0 = 2'd2,
        PH_HIGH1 = 2'd3
    } scl_phase_t;

    // Shortest legal quarter length; the tick register looks one cycle ahead
    // of the quarter end, so a quarter must last at least two cycles.
    localparam int DIV_MIN = 2;

endpackage

// File: rtl/i2c_scl_gen_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic d,
    output logic q
);

    logic meta;

    // Shift the async input through two flops to settle metastability.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            meta <= RESET_VAL;
            q    <= RESET_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/i2c_scl_gen.sv
// Programmable SCL timing generator for the AXIS I2C master.
// Each SCL period is four equal quarters of div_q clocks; tick_o strobes the
// last cycle of every quarter. Slave clock stretching is compiled in only
// when the macro I2C_SCL_STRETCH_EN is defined.
//
// Handshake: en_i is a level request, not a strobe. It is looked at only in
// IDLE and on the last cycle of quarter 3, so a period once started always
// completes; busy_o reports that a period is in progress.
module i2c_scl_gen
    import i2c_pkg::*;
#(
    parameter int CLK_IN   = 100_000_000,
    parameter int SCL_FREQ = 100_000,
    parameter int DIV_W    = 16
) (
    input  logic             clk_i,
    input  logic             arstn_i,
    input  logic             en_i,
    input  logic [DIV_W-1:0] div_i,
    input  logic             scl_i,
    output logic             scl_o,
    output logic             tick_o,
    output logic [1:0]       phase_o,
    output logic             busy_o,
    output logic             stretch_o,
    output scl_state_t       state_o
);

    localparam int DIV_DEFAULT = CLK_IN / (4 * SCL_FREQ);
    localparam logic [DIV_W-1:0] DIV_DEF_Q = DIV_W'(DIV_DEFAULT);
    localparam logic [DIV_W-1:0] DIV_MIN_Q = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] ONE       = DIV_W'(1);
    localparam logic [DIV_W-1:0] TWO       = DIV_W'(2);

    scl_state_t       state;
    scl_phase_t       phase;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic             cnt_last;
    logic             stretch_req;

    // Map the requested divider onto a legal quarter length.
    function automatic logic [DIV_W-1:0] eff_div(input logic [DIV_W-1:0] d);
        if (d == '0)
            return DIV_DEF_Q;
        else if (d < DIV_MIN_Q)
            return DIV_MIN_Q;
        else
            return d;
    endfunction

`ifdef I2C_SCL_STRETCH_EN
    logic scl_sync;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_scl_sync (
        .clk_i   (clk_i),
        .arstn_i (arstn_i),
        .d       (scl_i),
        .q       (scl_sync)
    );

    // A slave holding SCL low on the first high-quarter cycle pauses the count.
    assign stretch_req = (phase == PH_HIGH0) && (cnt == '0) && !scl_sync;
`else
    logic unused_scl;
    assign unused_scl  = scl_i;
    assign stretch_req = 1'b0;
`endif

    assign cnt_last = (cnt == div_q - ONE);

    // Single state machine: counter, quarter sequencing and all registered outputs.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= IDLE;
            phase     <= PH_LOW0;
            cnt       <= '0;
            div_q     <= DIV_DEF_Q;
            scl_o     <= 1'b1;
            tick_o    <= 1'b0;
            busy_o    <= 1'b0;
            stretch_o <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tick_o    <= 1'b0;
                    stretch_o <= 1'b0;
                    phase     <= PH_LOW0;
                    cnt       <= '0;
                    if (en_i) begin
                        state  <= RUN;
                        div_q  <= eff_div(div_i);
                        busy_o <= 1'b1;
                        scl_o  <= 1'b0;
                    end else begin
                        busy_o <= 1'b0;
                        scl_o  <= 1'b1;
                    end
                end

                RUN: begin
                    if (stretch_req) begin
                        state     <= STRETCH;
                        stretch_o <= 1'b1;
                        tick_o    <= 1'b0;
                        cnt       <= '0;
                    end else if (cnt_last) begin
                        cnt    <= '0;
                        tick_o <= 1'b0;
                        if (phase == PH_HIGH1) begin
                            phase <= PH_LOW0;
                            if (en_i) begin
                                div_q <= eff_div(div_i);
                                scl_o <= 1'b0;
                            end else begin
                                state  <= IDLE;
                                busy_o <= 1'b0;
                                scl_o  <= 1'b1;
                            end
                        end else begin
                            phase <= scl_phase_t'(phase + 2'd1);
                            scl_o <= (phase != PH_LOW0);
                        end
                    end else begin
                        cnt    <= cnt + ONE;
                        tick_o <= (cnt == div_q - TWO);
                    end
                end

                STRETCH: begin
                    tick_o <= 1'b0;
                    cnt    <= '0;
                    scl_o  <= 1'b1;
`ifdef I2C_SCL_STRETCH_EN
                    if (scl_sync) begin
                        state     <= RUN;
                        stretch_o <= 1'b0;
                    end
`else
                    state     <= RUN;
                    stretch_o <= 1'b0;
`endif
                end

                default: begin
                    state  <= IDLE;
                    phase  <= PH_LOW0;
                    cnt    <= '0;
                    scl_o  <= 1'b1;
                    tick_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

    assign phase_o = phase;
    assign state_o = state;

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Bench for i2c_scl_gen: table of divider runs checked quarter by quarter
// against an expected queue, plus hand sequences for mid-period changes,
// reset and clock stretching.
module tb_i2c_scl_gen;
    import i2c_pkg::*;

    localparam int DIV_W = 16;
    localparam int W     = 19;

    // clock / reset
    logic clk = 1'b0;
    logic arstn = 1'b0;
    always #5 clk = ~clk;

    logic             en = 1'b0;
    logic [DIV_W-1:0] div = '0;
    logic             scl_in = 1'b1;
    logic             scl_o, tick_o, busy_o, stretch_o;
    logic [1:0]       phase_o;
    scl_state_t       state_o;

    i2c_scl_gen #(
        .CLK_IN   (100_000_000),
        .SCL_FREQ (100_000),
        .DIV_W    (DIV_W)
    ) dut (
        .clk_i     (clk),
        .arstn_i   (arstn),
        .en_i      (en),
        .div_i     (div),
        .scl_i     (scl_in),
        .scl_o     (scl_o),
        .tick_o    (tick_o),
        .phase_o   (phase_o),
        .busy_o    (busy_o),
        .stretch_o (stretch_o),
        .state_o   (state_o)
    );

    int total = 0;
    int bad = 0;
    int tick_cnt = 0;
    int qlen = 0;
    logic mon_on = 1'b0;
    logic seen_stretch = 1'b0;
    logic [W-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected record per quarter: {phase, scl level, quarter length}.
    task automatic push_period(input int len);
        for (int q = 0; q < 4; q++) begin
            logic [1:0] qp;
            logic       lvl;
            qp  = 2'(q);
            lvl = (q >= 2);
            exp_q.push_back({qp, lvl, 16'(len)});
        end
    endtask

    // Monitor: measure each quarter and compare against the queue head.
    always @(negedge clk) begin
        if (!arstn) begin
            qlen = 0;
        end else begin
            if (stretch_o) seen_stretch = 1'b1;
            if (tick_o && !busy_o) check("tick_in_idle", 32'(tick_o), 32'd0);
            if (busy_o) begin
                qlen++;
                if (tick_o) begin
                    tick_cnt++;
                    if (mon_on) begin
                        if (exp_q.size() == 0) begin
                            check("unexpected_tick", 32'(tick_cnt), 32'd0);
                        end else begin
                            logic [W-1:0] e;
                            e = exp_q.pop_front();
                            check("quarter", 32'({phase_o, scl_o, 16'(qlen)}), 32'(e));
                        end
                    end
                    qlen = 0;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int target);
        int k;
        k = 0;
        while (tick_cnt < target && k < 5000) begin
            step();
            k++;
        end
        if (tick_cnt < target) check("tick_timeout", 32'(tick_cnt), 32'(target));
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_o && k < 5000) begin
            step();
            k++;
        end
        step();
        check("idle_busy", 32'(busy_o), 32'd0);
        check("idle_scl", 32'(scl_o), 32'd1);
        check("idle_phase", 32'(phase_o), 32'd0);
        check("idle_state", 32'(state_o), 32'(IDLE));
        check("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Run n whole periods; en drops during quarter 1 of the last one.
    task automatic run_periods(input logic [DIV_W-1:0] d, input int n, input int len);
        int start;
        step();
        start = tick_cnt;
        div = d;
        for (int p = 0; p < n; p++) push_period(len);
        en = 1'b1;
        wait_ticks(start + 4 * n - 3);
        en = 1'b0;
        wait_idle();
    endtask

    typedef struct {
        logic [DIV_W-1:0] div;
        int               periods;
        int               qlen;
    } vec_t;

    vec_t vt[6];

    initial begin
        #3000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int start;
        vt[0] = '{16'd4, 2, 4};
        vt[1] = '{16'd0, 1, 250};
        vt[2] = '{16'd1, 2, 2};
        vt[3] = '{16'd7, 2, 7};
        vt[4] = '{16'd2, 1, 2};
        vt[5] = '{16'd3, 3, 3};

        // reset state
        #12;
        check("rst_scl", 32'(scl_o), 32'd1);
        check("rst_tick", 32'(tick_o), 32'd0);
        check("rst_phase", 32'(phase_o), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_stretch", 32'(stretch_o), 32'd0);
        check("rst_state", 32'(state_o), 32'(IDLE));
        step();
        arstn = 1'b1;
        repeat (3) step();
        check("idle_no_en", 32'(busy_o), 32'd0);

        // table-driven divider runs
        mon_on = 1'b1;
        for (int i = 0; i < 6; i++) run_periods(vt[i].div, vt[i].periods, vt[i].qlen);

        // divider change and en glitch mid-period: current period stays 16 cycles
        step();
        start = tick_cnt;
        div = 16'd4;
        push_period(4);
        push_period(6);
        en = 1'b1;
        wait_ticks(start + 1);
        en = 1'b0;
        wait_ticks(start + 2);
        en = 1'b1;
        div = 16'd6;
        wait_ticks(start + 5);
        en = 1'b0;
        wait_idle();

`ifdef I2C_SCL_STRETCH_EN
        // slave stretch at quarter 2
        begin
            int k;
            int n;
            int t0;
            mon_on = 1'b0;
            step();
            start = tick_cnt;
            div = 16'd4;
            en = 1'b1;
            wait_ticks(start + 1);
            scl_in = 1'b0;
            wait_ticks(start + 2);
            k = 0;
            while (!stretch_o && k < 10) begin
                step();
                k++;
            end
            check("stretch_on", 32'(stretch_o), 32'd1);
            check("stretch_scl", 32'(scl_o), 32'd1);
            t0 = tick_cnt;
            repeat (20) step();
            check("no_tick_stretch", 32'(tick_cnt), 32'(t0));
            check("stretch_held", 32'(stretch_o), 32'd1);
            en = 1'b0;
            scl_in = 1'b1;
            k = 0;
            while (stretch_o && k < 20) begin
                step();
                k++;
            end
            check("stretch_off", 32'(stretch_o), 32'd0);
            n = 1;
            while (!tick_o && n < 20) begin
                step();
                n++;
            end
            check("q2_after_stretch", 32'(n), 32'd4);
            check("q2_phase", 32'(phase_o), 32'd2);
            wait_idle();
            mon_on = 1'b1;
        end
`else
        // scl_i has no effect without stretch support
        scl_in = 1'b0;
        run_periods(16'd4, 1, 4);
        scl_in = 1'b1;
        check("stretch_tied0", 32'(seen_stretch), 32'd0);
`endif

        // asynchronous reset mid quarter 2
        mon_on = 1'b0;
        step();
        start = tick_cnt;
        div = 16'd4;
        en = 1'b1;
        wait_ticks(start + 2);
        step();
        check("busy_before_rst", 32'(busy_o), 32'd1);
        @(negedge clk);
        #2;
        arstn = 1'b0;
        #1;
        check("arst_scl", 32'(scl_o), 32'd1);
        check("arst_busy", 32'(busy_o), 32'd0);
        check("arst_phase", 32'(phase_o), 32'd0);
        check("arst_tick", 32'(tick_o), 32'd0);
        en = 1'b0;
        step();
        arstn = 1'b1;
        exp_q.delete();
        mon_on = 1'b1;

        // div_i = 1 clamps to a 2-cycle quarter after reset
        run_periods(16'd1, 1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
